muldiv_unit: RTL

//  Iterative multiply/divide unit for the EX stage. It sits in parallel with the ALU and takes the same forwarded operands.

---
 rtl/muldiv_if.sv | 17 +
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// EX-stage request/response bundle for muldiv_unit: operands and op in, busy/done and HI/LO out.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, flush, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with MTHI/MTLO; owns the HI/LO registers.
// Define MULDIV_DIV_EN to build the restoring divider; without it DIV/DIVU are nops.
module muldiv_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] HILO_RST = '0
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;      // mul: {partial product, multiplier}; div: low half is dividend/quotient
    logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
    logic               q_neg;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               signed_op;
    logic               accept_op;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] prod;

`ifdef MULDIV_DIV_EN
    logic               is_div;
    logic               r_neg;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_trial;
    logic [WIDTH-1:0]   quot_res;
    logic [WIDTH-1:0]   rem_res;
`endif

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
`ifdef MULDIV_DIV_EN
        accept_op = (bus.op[2] == 1'b0);
`else
        accept_op = (bus.op[2:1] == 2'b00);
`endif
        abs_a    = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b    = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        prod     = q_neg ? -acc : acc;
`ifdef MULDIV_DIV_EN
        // Partial remainder is one bit wider so the trial subtraction's sign is its MSB.
        rem_shift = {rem, acc[WIDTH-1]};
        rem_trial = rem_shift - {1'b0, opnd};
        quot_res  = q_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_res   = r_neg ? -rem : rem;
`endif
    end

    // NOTE: all state here is clocked, so it uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: datapath registers are reset too; they are plain flops, not a memory array.
            state  <= IDLE;
            count  <= '0;
            acc    <= '0;
            opnd   <= '0;
            q_neg  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= HILO_RST;
            lo_q   <= HILO_RST;
`ifdef MULDIV_DIV_EN
            is_div <= 1'b0;
            r_neg  <= 1'b0;
            rem    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        if (accept_op) begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                            count  <= '0;
                            opnd   <= abs_b;
                            acc    <= {{WIDTH{1'b0}}, abs_a};
                            // A zero divisor keeps the all-ones quotient un-negated.
                            q_neg  <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) && (|bus.b);
`ifdef MULDIV_DIV_EN
                            is_div <= bus.op[1];
                            r_neg  <= signed_op && bus.a[WIDTH-1];
                            rem    <= '0;
`endif
                        end else if (bus.op == OP_MTHI) begin
                            hi_q <= bus.a;
                        end else if (bus.op == OP_MTLO) begin
                            lo_q <= bus.a;
                        end
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        count <= count + CW'(1);
`ifdef MULDIV_DIV_EN
                        if (is_div) begin
                            if (!rem_trial[WIDTH]) begin
                                rem               <= rem_trial[WIDTH-1:0];
                                acc[WIDTH-1:0]    <= {acc[WIDTH-2:0], 1'b1};
                            end else begin
                                rem               <= rem_shift[WIDTH-1:0];
                                acc[WIDTH-1:0]    <= {acc[WIDTH-2:0], 1'b0};
                            end
                        end else
`endif
                        acc <= mul_next;
                        if (count == CW'(WIDTH - 1)) state <= FIX;
                    end
                end
                FIX: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    if (!bus.flush) begin
                        done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
                        if (is_div) begin
                            hi_q <= rem_res;
                            lo_q <= quot_res;
                        end else
`endif
                        {hi_q, lo_q} <= prod;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
